// File: rtl/uart_tx_fifo.sv
// UART transmitter with byte FIFO: queues bytes, serialises 8N1 (8E1 with UART_TX_PARITY_EN) LSB first on tx_uart.
// Latency: byte pushed into an empty FIFO at edge N drives the start bit from edge N+1; frames go back-to-back.
// Backpressure: tx_ready = !full; a push while full is ignored. Optional feature macro: UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_uart,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Registered state
  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            push;
  logic            pop;
  logic            baud_end;
  logic [7:0]      rd_dat;

  assign tx_ready = (cnt_q != FULL_CNT);
  assign push     = tx_valid && tx_ready;
  assign rd_dat   = mem_q[rd_ptr_q];
  assign baud_end = (baud_q == BAUD_LAST);
  assign tx_uart  = tx_q;
  assign fifo_cnt = cnt_q;
  assign busy     = (state_q != S_IDLE) || (cnt_q != '0);

  // Frame sequencer: decides the next line level and when to pop the next byte
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap
          if (cnt_q != '0) begin
            pop     = 1'b1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (pop) begin
      shift_d = rd_dat;
`ifdef UART_TX_PARITY_EN
      par_d   = ^rd_dat;
`endif
    end
  end

  // FIFO pointers and occupancy; a same-edge push and pop leaves the count unchanged
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // All control state; reset abandons any partial frame and flushes the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at BAUD_DIV=10, FIFO_DEPTH=4.
// Table of single bytes with hand-written frames, plus burst, full-drop, push+pop and mid-frame reset sequences.
module tb_uart_tx_fifo;

  localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_uart;
  logic       busy;
  logic [2:0] fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_uart (tx_uart),
    .busy    (busy),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  // Frame layout {stop, even parity, data[7:0], start}; parity column hand-computed
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [10:0] f, input int i);
    if (NB == 10 && i == 9) return f[10];
    return f[i];
  endfunction

  // Called one step after the edge that drives the start bit; leaves one step after the frame's last edge
  task automatic check_frame(input string name, input logic [10:0] f);
    logic bad;
    logic got_line;
    logic got_busy;
    for (int i = 0; i < NB; i++) begin
      bad = 1'b0;
      got_line = 1'b0;
      got_busy = 1'b0;
      for (int c = 0; c < BD; c++) begin
        if ((tx_uart !== exp_bit(f, i)) || (busy !== 1'b1)) begin
          if (!bad) begin
            got_line = tx_uart;
            got_busy = busy;
          end
          bad = 1'b1;
        end
        tick();
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL %s bit%0d: line=%b busy=%b, required line=%b busy=1",
                 name, i, got_line, got_busy, exp_bit(f, i));
      end
    end
  endtask

  task automatic wait_low(output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (tx_uart === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_single(input vec_t v);
    tx_data  = v.data;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~v.data;
    chk("single_line_at_push", tx_uart, 1);
    chk("single_cnt_at_push", fifo_cnt, 1);
    chk("single_busy_at_push", busy, 1);
    tick();
    check_frame($sformatf("single_%02h", v.data), v.frame);
    chk("single_idle_line", tx_uart, 1);
    chk("single_busy_drop", busy, 0);
    chk("single_cnt_end", fifo_cnt, 0);
    chk("single_ready_end", tx_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  burst_dat [5];
    logic [10:0] burst_frm [5];
    int          burst_cnt [5];
    logic [7:0]  pp_dat [4];
    logic [10:0] pp_frm [4];
    bit          quiet;

    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'h55, 11'b1_0_01010101_0};
    vecs[4] = '{8'h3C, 11'b1_0_00111100_0};
    vecs[5] = '{8'h81, 11'b1_0_10000001_0};
    vecs[6] = '{8'h07, 11'b1_1_00000111_0};
    vecs[7] = '{8'h03, 11'b1_0_00000011_0};

    burst_dat = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81};
    burst_frm = '{11'b1_0_00000000_0, 11'b1_0_11111111_0, 11'b1_0_01010101_0,
                  11'b1_0_00111100_0, 11'b1_0_10000001_0};
    burst_cnt = '{1, 1, 2, 3, 4};

    pp_dat = '{8'h12, 8'h34, 8'h56, 8'h78};
    pp_frm = '{11'b1_0_00010010_0, 11'b1_1_00110100_0, 11'b1_0_01010110_0,
               11'b1_0_01111000_0};

    // Reset state
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) tick();
    chk("reset_line", tx_uart, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_cnt", fifo_cnt, 0);
    rst = 1'b0;
    repeat (2) tick();
    chk("post_reset_line", tx_uart, 1);
    chk("post_reset_busy", busy, 0);

    // Single bytes from the table
    for (int v = 0; v < 8; v++) begin
      send_single(vecs[v]);
      repeat (3) tick();
    end

    // Burst: five consecutive pushes, then an extra push while full
    fork
      begin
        tx_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tx_data = burst_dat[k];
          tick();
          chk($sformatf("burst_cnt_%0d", k), fifo_cnt, burst_cnt[k]);
        end
        chk("burst_full_ready", tx_ready, 0);
        tx_data = 8'hEE;
        tick();
        chk("burst_drop_cnt", fifo_cnt, 4);
        tx_valid = 1'b0;
      end
      begin
        bit ok;
        int lat;
        wait_low(ok, lat);
        chk("burst_latency", lat, 2);
        if (ok) begin
          for (int k = 0; k < 5; k++)
            check_frame($sformatf("burst_%0d", k), burst_frm[k]);
        end
      end
    join
    chk("burst_idle_line", tx_uart, 1);
    chk("burst_busy_drop", busy, 0);
    chk("burst_cnt_end", fifo_cnt, 0);
    repeat (3) tick();

    // Push coinciding with the pop at the end of a stop bit, count 2
    fork
      begin
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tx_data = pp_dat[k];
          tick();
        end
        tx_valid = 1'b0;
        chk("pp_cnt_before", fifo_cnt, 2);
        repeat (NB * BD - 2) tick();
        chk("pp_cnt_at_stop", fifo_cnt, 2);
        tx_valid = 1'b1;
        tx_data  = pp_dat[3];
        tick();
        tx_valid = 1'b0;
        chk("pp_cnt_after", fifo_cnt, 2);
      end
      begin
        bit ok;
        int lat;
        wait_low(ok, lat);
        chk("pp_latency", lat, 2);
        if (ok) begin
          for (int k = 0; k < 4; k++)
            check_frame($sformatf("pp_%0d", k), pp_frm[k]);
        end
      end
    join
    chk("pp_idle_line", tx_uart, 1);
    chk("pp_busy_drop", busy, 0);
    repeat (3) tick();

    // Asynchronous reset in the middle of a start bit with one byte still queued
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick();
    tx_data  = 8'h3C;
    tick();
    tx_valid = 1'b0;
    repeat (4) tick();
    chk("mid_pre_line", tx_uart, 0);
    chk("mid_pre_cnt", fifo_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_line", tx_uart, 1);
    chk("mid_reset_cnt", fifo_cnt, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_ready", tx_ready, 1);
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (tx_uart !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("mid_reset_no_resume", quiet, 1);
    send_single(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
